// File: rtl/tti_rx_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : tti_rx_byte_packer
// Purpose  : Packs the 8-bit valid/ready byte stream from the standby
//            controller RX data port into OutDataWidth-bit words for the TTI
//            RX data queue. Byte lanes fill little-endian (byte k in bits
//            [8k+7:8k]). Each word carries a contiguous byte strobe and an
//            end-of-transfer flag. A transfer closes on in_last_i or on a
//            flush_i pulse; either one emits any partial word.
// Ports    : clk_i, rst_i (async, active high)
//            in_valid_i / in_ready_o / in_data_i / in_last_i : byte input
//            flush_i                                         : close transfer
//            out_valid_o / out_ready_i / out_data_o /
//            out_strb_o / out_last_o                         : word output
//            byte_count_o : bytes accepted in the current transfer
//                           (saturates at 0xFFFF)
// Config   : I3C_RX_PACKER_SKID_EN
//              defined   - 2-entry output FIFO, registered in_ready_o
//              undefined - single output register, in_ready_o combinational
//                          from out_ready_i
// Revision : 1.0 - initial release
// ============================================================================
module tti_rx_byte_packer #(
  parameter int OutDataWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [7:0]                in_data_i,
  input  logic                      in_last_i,
  input  logic                      flush_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [OutDataWidth-1:0]   out_data_o,
  output logic [OutDataWidth/8-1:0] out_strb_o,
  output logic                      out_last_o,
  output logic [15:0]               byte_count_o
);

  localparam int              BPW      = OutDataWidth / 8;
  localparam int              IDX_W    = $clog2(BPW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BPW - 1);

  // Accumulator and transfer state
  logic [OutDataWidth-1:0] acc_q, acc_d;
  logic [BPW-1:0]          acc_strb_q, acc_strb_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [15:0]             byte_count_q, byte_count_d;
  logic                    flush_pending_q, flush_pending_d;
  logic                    clr_count_q, clr_count_d;

  // Per-cycle control
  logic                    hs;
  logic                    flush_req;
  logic                    cmp_byte;
  logic                    cmp_flush;
  logic                    stage_free;
  logic                    load;
  logic [OutDataWidth-1:0] word_data;
  logic [BPW-1:0]          word_strb;
  logic                    word_last;
  logic [15:0]             count_base;

  // --------------------------------------------------------------------------
  // Packing and word-completion control
  // --------------------------------------------------------------------------
  always_comb begin
    flush_req = flush_i | flush_pending_q;
    hs        = in_valid_i & in_ready_o;

    // Word as it would look with this cycle's byte merged in. Lanes above idx
    // are still zero because the accumulator is cleared on every completion.
    word_data = acc_q;
    word_strb = acc_strb_q;
    for (int k = 0; k < BPW; k++) begin
      if (hs && (idx_q == IDX_W'(k))) begin
        word_data[8*k +: 8] = in_data_i;
        word_strb[k]        = 1'b1;
      end
    end

    cmp_byte  = hs & ((idx_q == IDX_LAST) | in_last_i | flush_req);
    cmp_flush = ~hs & flush_req & (|acc_strb_q);
    // Only a lane-filling byte with no last/flush leaves the transfer open.
    word_last = ~hs | in_last_i | flush_req;

    load            = (cmp_byte | cmp_flush) & stage_free;
    // Flush that found the output stage busy is retried every cycle.
    flush_pending_d = cmp_flush & ~stage_free;
    clr_count_d     = load & word_last;

    if (load) begin
      acc_d      = '0;
      acc_strb_d = '0;
      idx_d      = '0;
    end else if (hs) begin
      acc_d      = word_data;
      acc_strb_d = word_strb;
      idx_d      = idx_q + 1'b1;
    end else begin
      acc_d      = acc_q;
      acc_strb_d = acc_strb_q;
      idx_d      = idx_q;
    end

    // Count restarts one cycle after a closing word was loaded; a byte
    // accepted in that same cycle belongs to the new transfer.
    count_base   = clr_count_q ? 16'd0 : byte_count_q;
    byte_count_d = (hs && (count_base != 16'hFFFF)) ? count_base + 16'd1
                                                    : count_base;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q           <= '0;
      acc_strb_q      <= '0;
      idx_q           <= '0;
      byte_count_q    <= '0;
      flush_pending_q <= 1'b0;
      clr_count_q     <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      acc_strb_q      <= acc_strb_d;
      idx_q           <= idx_d;
      byte_count_q    <= byte_count_d;
      flush_pending_q <= flush_pending_d;
      clr_count_q     <= clr_count_d;
    end
  end

  assign byte_count_o = byte_count_q;

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
`ifdef I3C_RX_PACKER_SKID_EN

  logic [1:0][OutDataWidth-1:0] fifo_data_q, fifo_data_d;
  logic [1:0][BPW-1:0]          fifo_strb_q, fifo_strb_d;
  logic [1:0]                   fifo_last_q, fifo_last_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic [1:0]                   fifo_count_q, fifo_count_d;
  logic                         in_ready_q, in_ready_d;
  logic                         pop;

  always_comb begin
    pop        = (fifo_count_q != 2'd0) & out_ready_i;
    // A full FIFO can still take a word when the head leaves this cycle.
    stage_free = (fifo_count_q != 2'd2) | out_ready_i;
  end

  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_strb_d = fifo_strb_q;
    fifo_last_d = fifo_last_q;
    if (load) begin
      fifo_data_d[wr_ptr_q] = word_data;
      fifo_strb_d[wr_ptr_q] = word_strb;
      fifo_last_d[wr_ptr_q] = word_last;
    end
    wr_ptr_d     = wr_ptr_q ^ load;
    rd_ptr_d     = rd_ptr_q ^ pop;
    fifo_count_d = fifo_count_q + {1'b0, load} - {1'b0, pop};
    // Registered from next-state values so in_ready_o never depends
    // combinationally on out_ready_i.
    in_ready_d   = (fifo_count_d != 2'd2) & ~flush_pending_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fifo_data_q  <= '0;
      fifo_strb_q  <= '0;
      fifo_last_q  <= '0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_count_q <= 2'd0;
      in_ready_q   <= 1'b1;
    end else begin
      fifo_data_q  <= fifo_data_d;
      fifo_strb_q  <= fifo_strb_d;
      fifo_last_q  <= fifo_last_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_count_q <= fifo_count_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = (fifo_count_q != 2'd0);
  assign out_data_o  = fifo_data_q[rd_ptr_q];
  assign out_strb_o  = fifo_strb_q[rd_ptr_q];
  assign out_last_o  = fifo_last_q[rd_ptr_q];

`else

  logic                    out_valid_q, out_valid_d;
  logic [OutDataWidth-1:0] out_data_q, out_data_d;
  logic [BPW-1:0]          out_strb_q, out_strb_d;
  logic                    out_last_q, out_last_d;

  always_comb begin
    stage_free  = ~out_valid_q | out_ready_i;
    out_valid_d = load | (out_valid_q & ~out_ready_i);
    out_data_d  = load ? word_data : out_data_q;
    out_strb_d  = load ? word_strb : out_strb_q;
    out_last_d  = load ? word_last : out_last_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_last_q  <= out_last_d;
    end
  end

  assign in_ready_o  = (~out_valid_q | out_ready_i) & ~flush_pending_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_strb_o  = out_strb_q;
  assign out_last_o  = out_last_q;

`endif

endmodule
`default_nettype wire
